// File: rtl/seg7_pkg.sv
// Shared constants, hex-to-segment table and digit type for the 4-digit
// 7-segment scan driver.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG7_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Active-low a..g patterns; element [k] is the pattern for code k (F first, 0 last).
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Marks digits 3..1 that belong to an all-zero, no-decimal-point leading run.
  function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic [3:0] dps);
    logic [3:0] m;
    logic       run;
    m   = 4'b0000;
    run = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      run  = run && (d[4*i +: 4] == 4'h0) && !dps[i];
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit code to active-low 7-segment (a..g = bit 0..6) decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);

  assign seg = HEX7_TABLE[code];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot and guard interval.
// Optional build macro: SEG7_LZ_BLANK_EN (leading-zero suppression folded into the blank mask).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        scan_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic [3:0]       snap_dp;
  logic [3:0]       snap_blank;

  logic       at_last;
  logic       load_snap;
  logic       dark;
  logic [3:0] new_blank;
  digit_t     sel_code;
  logic [6:0] sel_seg;

  assign at_last   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign load_snap = enable && (cnt == '0) && (idx == 2'd0);
  assign dark      = !enable || (cnt < CNT_W'(GUARD)) || snap_blank[idx];
  assign sel_code  = snap[4*idx +: 4];
  assign digit_idx = idx;

`ifdef SEG7_LZ_BLANK_EN
  assign new_blank = blank_in | lz_mask(digits, dp_in);
`else
  assign new_blank = blank_in;
`endif

  hex_to_seg7 u_hex (
    .code (sel_code),
    .seg  (sel_seg)
  );

  // Outputs reflect the pre-edge state, so an/seg/dp always move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      snap_dp    <= 4'b0000;
      snap_blank <= 4'b0000;
      an         <= AN_OFF;
      seg        <= SEG7_OFF;
      dp         <= 1'b1;
      scan_tick  <= 1'b0;
    end else begin
      scan_tick <= enable && at_last;
      if (enable) begin
        if (at_last) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (load_snap) begin
          snap       <= digits;
          snap_dp    <= dp_in;
          snap_blank <= new_blank;
        end
      end
      if (dark) begin
        an  <= AN_OFF;
        seg <= SEG7_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= sel_seg;
        dp  <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: frame-position scoreboard plus directed literal checks.
module tb_seg7_scan_driver;

  localparam int RDIV  = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * RDIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blank_in = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.REFRESH_DIV(RDIV), .GUARD(GRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the scan is a position 0..FRAME-1 within the frame, advanced on enabled cycles.
  int         pos = 0;
  logic [3:0] msnap [4];
  logic [3:0] mdp = 4'b0000;
  logic [3:0] mblank = 4'b0000;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    int         slot;
    int         off;
    bit         lead;
    e_an   = 4'b1111;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    e_tick = 1'b0;
    lead   = 1'b1;
    if (reset) begin
      pos = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 4'h0;
      mdp         = 4'b0000;
      mblank      = 4'b0000;
      model_valid = 1'b1;
    end else begin
      slot   = pos / RDIV;
      off    = pos % RDIV;
      e_tick = enable && (off == RDIV - 1);
      if (enable && off >= GRD && !mblank[slot]) begin
        e_an[slot] = 1'b0;
        e_seg      = seg_ref[msnap[slot]];
        e_dp       = !mdp[slot];
      end
      if (enable && pos == 0) begin
        for (int i = 0; i < 4; i++) msnap[i] = digits[4*i +: 4];
        mdp    = dp_in;
        mblank = blank_in;
`ifdef SEG7_LZ_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
          if (msnap[i] != 4'h0 || mdp[i]) lead = 1'b0;
          if (lead) mblank[i] = 1'b1;
        end
`endif
      end
      if (enable) pos = (pos + 1) % FRAME;
    end
    #1;
    if (model_valid) begin
      cmp("sb.an",   8'(an),        8'(e_an));
      cmp("sb.seg",  8'(seg),       8'(e_seg));
      cmp("sb.dp",   8'(dp),        8'(e_dp));
      cmp("sb.tick", 8'(scan_tick), 8'(e_tick));
      cmp("sb.idx",  8'(digit_idx), 8'(pos / RDIV));
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] dig,
                               input logic [3:0] dpi, input logic [3:0] bl);
    reset    = rst;
    enable   = en;
    digits   = dig;
    dp_in    = dpi;
    blank_in = bl;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic [1:0] e_idx, input logic e_tick);
    cmp({tag, ".an"},   8'(an),        8'(e_an));
    cmp({tag, ".seg"},  8'(seg),       8'(e_seg));
    cmp({tag, ".dp"},   8'(dp),        8'(e_dp));
    cmp({tag, ".idx"},  8'(digit_idx), 8'(e_idx));
    cmp({tag, ".tick"}, 8'(scan_tick), 8'(e_tick));
  endtask

  initial begin
    runCycles(3);
    checkOutput("reset", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0000);
    runCycles(2);  checkOutput("guard0",  4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    runCycles(1);  checkOutput("d0_first",4'b1110, 7'h19, 1'b1, 2'd0, 1'b0);
    runCycles(5);  checkOutput("d0_last", 4'b1110, 7'h19, 1'b1, 2'd1, 1'b1);
    runCycles(3);  checkOutput("d1",      4'b1101, 7'h30, 1'b1, 2'd1, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'hABCD, 4'b0000, 4'b0000);
    runCycles(8);  checkOutput("d2_old",  4'b1011, 7'h24, 1'b1, 2'd2, 1'b0);
    runCycles(8);  checkOutput("d3_old",  4'b0111, 7'h79, 1'b1, 2'd3, 1'b0);
    runCycles(5);  checkOutput("wrap",    4'b0111, 7'h79, 1'b1, 2'd0, 1'b1);
    runCycles(3);  checkOutput("new_d0",  4'b1110, 7'h21, 1'b1, 2'd0, 1'b0);
    runCycles(8);  checkOutput("new_d1",  4'b1101, 7'h46, 1'b1, 2'd1, 1'b0);
    runCycles(8);  checkOutput("new_d2",  4'b1011, 7'h03, 1'b1, 2'd2, 1'b0);
    runCycles(8);  checkOutput("new_d3",  4'b0111, 7'h08, 1'b1, 2'd3, 1'b0);
    runCycles(5);

    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100, 4'b1000);
    runCycles(3);  checkOutput("dpbl_d0", 4'b1110, 7'h19, 1'b1, 2'd0, 1'b0);
    runCycles(8);  checkOutput("dpbl_d1", 4'b1101, 7'h30, 1'b1, 2'd1, 1'b0);
    runCycles(8);  checkOutput("dpbl_d2", 4'b1011, 7'h24, 1'b0, 2'd2, 1'b0);
    runCycles(8);  checkOutput("dpbl_d3", 4'b1111, 7'h7F, 1'b1, 2'd3, 1'b0);
    runCycles(5);
    runCycles(4);

    applyStimulus(1'b0, 1'b0, 16'h1234, 4'b0100, 4'b1000);
    runCycles(1);  checkOutput("dis",     4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    runCycles(4);  checkOutput("dis_end", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100, 4'b1000);
    runCycles(1);  checkOutput("resume",  4'b1110, 7'h19, 1'b1, 2'd0, 1'b0);
    runCycles(3);  checkOutput("res_tick",4'b1110, 7'h19, 1'b1, 2'd1, 1'b1);
    runCycles(3);

    applyStimulus(1'b1, 1'b1, 16'h0070, 4'b0000, 4'b0000);
    runCycles(3);  checkOutput("midrst",  4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0070, 4'b0000, 4'b0000);
    runCycles(3);  checkOutput("z_d0",    4'b1110, 7'h40, 1'b1, 2'd0, 1'b0);
    runCycles(8);  checkOutput("z_d1",    4'b1101, 7'h78, 1'b1, 2'd1, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
    runCycles(8);  checkOutput("z_d2",    4'b1111, 7'h7F, 1'b1, 2'd2, 1'b0);
    runCycles(8);  checkOutput("z_d3",    4'b1111, 7'h7F, 1'b1, 2'd3, 1'b0);
`else
    runCycles(8);  checkOutput("z_d2",    4'b1011, 7'h40, 1'b1, 2'd2, 1'b0);
    runCycles(8);  checkOutput("z_d3",    4'b0111, 7'h40, 1'b1, 2'd3, 1'b0);
`endif
    runCycles(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the decimal/hex digit decoders.
- Time-multiplexes four 4-bit digit codes onto the shared active-low seg/an pins of the 4-digit 7-segment display.
- Scans one digit at a time. Holds a tear-free snapshot of the input digits for each full scan.
- Inserts a guard (ghost-suppression) interval at every digit change.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is selected. Range 4..2^20.
- GUARD, 2: cycles at the start of each digit slot during which all anodes are off. Range 1..REFRESH_DIV-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low = display dark, scan frozen
- digits  input  16  digit codes; digits[4i+3:4i] = digit i, digit 0 = rightmost
- dp_in  input  4  decimal-point request per digit, active-high
- blank_in  input  4  per-digit forced blank, active-high
- seg  output  7  segments a..g = seg[0]..seg[6], active-low, registered
- dp  output  1  decimal point, active-low, registered
- an  output  4  anode select, active-low, registered; an[i] drives digit i
- digit_idx  output  2  digit currently in its slot (state, not delayed)
- scan_tick  output  1  one-cycle pulse when the slot advances, registered

Behaviour:
- Reset values: cnt=0, idx=0, snap=16'h0000, snap_dp=0, snap_blank=0; an=4'b1111, seg=7'h7F, dp=1, scan_tick=0.
- Reset mid-scan: all of the above on the next edge; the scan restarts at digit 0.
- Prescaler cnt (width clog2(REFRESH_DIV)), only while enable=1:
  - cnt==REFRESH_DIV-1 → cnt=0, idx=idx+1 (wraps 3→0), scan_tick=1 on the next cycle.
  - Otherwise cnt=cnt+1.
- enable=0:
  - cnt and idx hold.
  - Registered outputs become an=1111, seg=7F, dp=1 on the next edge.
  - scan_tick=0.
- Snapshot: snap/snap_dp/snap_blank load from digits/dp_in/blank_in in any cycle with enable=1, cnt==0, idx==0. Mid-scan input changes appear only at the next scan start. The first enabled cycle after reset loads immediately.
- Output computation, registered one cycle after the state it reflects. Let d = snap[4*idx+3:4*idx].
  - Guard: if cnt<GUARD, or snap_blank[idx]=1, or enable=0 → an=1111, seg=7F, dp=1.
  - Else an = ~(4'b0001<<idx), seg = hex7(d), dp = ~snap_dp[idx].
- hex7 encoding, active-low a..g:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Exactly one anode is low at any time outside guard, or none.
- an and seg change on the same edge, never skewed.
- Full-frame period = 4*REFRESH_DIV cycles.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit i (i=3..1) is blanked if it and every higher digit in snap are 0 and snap_dp for those digits is 0.
  - Digit 0 is never auto-blanked.
  - Decided at snapshot load and stored as bits in the effective blank mask.
- Undefined: only blank_in blanks; zeros display as "0".

Decomposition:
- Package seg7_pkg:
  - Constant SEG7_OFF=7'h7F, AN_OFF=4'b1111.
  - The 16-entry hex7 constant table.
  - typedef digit_t (logic [3:0]).
- Sub-module: hex_to_seg7 (combinational, 4-bit code → 7-bit active-low segments, using the package table), instantiated once on the selected digit.

Test Plan (REFRESH_DIV=8, GUARD=2 unless noted):
- Reset → an=1111, seg=7F, dp=1, digit_idx=0, scan_tick=0. Hold reset 3 cycles mid-scan → same values, scan restarts at digit 0.
- enable=1, digits=16'h1234 → cycles 3..8 an=1110/seg=19 ('4'). Next slot an=1101/seg=30 ('3'). Then 1011/24, then 0111/79. scan_tick pulses every 8 cycles. an=1111 for 2 cycles at each slot start.
- Change digits to 16'hABCD during digit-1 slot → the rest of the frame still shows 1234. The next frame shows D,C,b,A (21,46,03,08).
- dp_in=4'b0100, blank_in=4'b1000 → dp=0 only while an=1011. Digit 3 slot keeps an=1111 throughout.
- enable dropped mid-slot for 5 cycles → outputs dark next edge, cnt/idx frozen. On re-enable the slot resumes with its remaining count.
- SEG7_LZ_BLANK_EN defined, digits=16'h0070 → digits 3,2 dark, digit 1 shows 78, digit 0 shows 40. Same stimulus with the macro undefined shows 0070.
